// File: rtl/ps2_keyscan.sv
// ps2_keyscan: PS/2 keyboard front end feeding the piano stage.
// Synchronizes and filters the raw PS/2 pins, assembles 11-bit frames,
// decodes the E0 (extended) and F0 (break) prefixes and emits one key event
// per keystroke, plus key_down tracking for the most recent make.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN -- when defined, a repeated
// make of the currently held key (keyboard auto-repeat) is suppressed.
//
// Handshake: key_valid is a one-cycle strobe with no back-pressure; key_code
// and key_release are valid in that cycle and hold until the next event.
// frame_err is a one-cycle strobe and never coincides with key_valid.
module ps2_keyscan #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       inclk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [8:0] key_code,
    output logic       key_release,
    output logic       key_valid,
    output logic       key_down,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic                  clk_s1, clk_s2, data_s1, data_s2;
    logic [FILTER_LEN-1:0] filt;
    logic                  clk_f, clk_f_next, fall;
    logic [1:0]            state;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  par_bit;
    logic [TW-1:0]         tcnt;
    logic                  timeout;
    logic                  byte_rdy, err_pulse;
    logic                  ext, brk;
    logic [8:0]            held_code;
    logic [8:0]            ev_code;
    logic                  suppress;

    // Two-flop synchronizers; idle-high reset values avoid a fake edge.
    always_ff @(posedge inclk) begin
        if (!reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Filtered clock level: changes only on a full window of equal samples.
    always_comb begin
        clk_f_next = clk_f;
        if (&filt)
            clk_f_next = 1'b1;
        else if (~|filt)
            clk_f_next = 1'b0;
    end

    // Glitch filter shift register, filtered level and falling-edge strobe.
    always_ff @(posedge inclk) begin
        if (!reset) begin
            filt  <= '1;
            clk_f <= 1'b1;
            fall  <= 1'b0;
        end else begin
            filt  <= {filt[FILTER_LEN-2:0], clk_s2};
            clk_f <= clk_f_next;
            fall  <= clk_f & ~clk_f_next;
        end
    end

    // A fall in the timeout cycle keeps the frame alive.
    assign timeout = (state != ST_IDLE) && !fall && (tcnt == TO_LAST);

    // Frame FSM with inactivity timeout; byte_rdy/err_pulse follow the stop bit.
    always_ff @(posedge inclk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            par_bit   <= 1'b0;
            tcnt      <= '0;
            byte_rdy  <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            byte_rdy  <= 1'b0;
            err_pulse <= 1'b0;
            if (fall || state == ST_IDLE)
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);

            if (timeout) begin
                state     <= ST_IDLE;
                err_pulse <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_s2) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= data_s2;
                        state   <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (data_s2 && (^{shreg, par_bit}))
                            byte_rdy <= 1'b1;
                        else
                            err_pulse <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ev_code   = {ext, shreg};
    assign frame_err = err_pulse;

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign suppress = key_down && (ev_code == held_code);
`else
    assign suppress = 1'b0;
`endif

    // Prefix decoder, event generation and held-key tracking.
    always_ff @(posedge inclk) begin
        if (!reset) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            key_code    <= 9'd0;
            key_release <= 1'b0;
            key_valid   <= 1'b0;
            key_down    <= 1'b0;
            held_code   <= 9'd0;
        end else begin
            key_valid <= 1'b0;
            if (err_pulse) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_rdy) begin
                if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else if (shreg == 8'h00 || shreg == 8'hFF) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (brk) begin
                        key_valid   <= 1'b1;
                        key_code    <= ev_code;
                        key_release <= 1'b1;
                        if (ev_code == held_code)
                            key_down <= 1'b0;
                    end else if (!suppress) begin
                        key_valid   <= 1'b1;
                        key_code    <= ev_code;
                        key_release <= 1'b0;
                        key_down    <= 1'b1;
                        held_code   <= ev_code;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyscan.sv
// tb_ps2_keyscan: self-checking bench for ps2_keyscan.
// Drives PS/2 frames on the pins, predicts key events with a keystroke-level
// model and compares every observed key_valid against an expected queue.
// Honours PS2_TYPEMATIC_FILTER_EN in the model.
module tb_ps2_keyscan;

    localparam int FL   = 8;
    localparam int TO   = 1500;
    localparam int HALF = 20;

    logic       inclk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] key_code;
    logic       key_release;
    logic       key_valid;
    logic       key_down;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_stop_cyc = 0;
    int obs_err = 0;
    int exp_err = 0;

    // Expected events: {release, code}
    logic [9:0] exp_q[$];

    // Keystroke-level model state
    bit         m_ext, m_brk, m_down, m_rel;
    logic [8:0] m_held, m_code;

    ps2_keyscan #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .inclk      (inclk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .key_release(key_release),
        .key_valid  (key_valid),
        .key_down   (key_down),
        .frame_err  (frame_err)
    );

    // Clock and cycle counter
    always #10 inclk = ~inclk;
    always @(posedge inclk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge inclk);
        #1;
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_down = 0; m_rel = 0;
        m_held = '0; m_code = '0;
        exp_q.delete();
    endtask

    // Keystroke rules applied to one received frame.
    task automatic model_frame(input logic [7:0] b, input bit good);
        logic [8:0] code;
        bit         sup;
        if (!good) begin
            exp_err++;
            m_ext = 0; m_brk = 0;
            return;
        end
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'h00 || b == 8'hFF) begin m_ext = 0; m_brk = 0; end
        else begin
            code = {m_ext, b};
            if (m_brk) begin
                exp_q.push_back({1'b1, code});
                m_code = code; m_rel = 1;
                if (m_down && code == m_held) m_down = 0;
            end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                sup = m_down && (code == m_held);
`else
                sup = 0;
`endif
                if (!sup) begin
                    exp_q.push_back({1'b0, code});
                    m_code = code; m_rel = 0;
                    m_down = 1; m_held = code;
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // One PS/2 bit: data set while clock high, then a low and a high phase.
    task automatic ps2_bit(input logic d, input bit is_stop);
        ps2_data = d;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        if (is_stop) last_stop_cyc = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        model_frame(b, !(bad_par || bad_stop));
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
        ps2_bit((~^b) ^ bad_par, 0);
        ps2_bit(!bad_stop, 1);
        ps2_data = 1'b1;
        wait_cyc(30);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0, 0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i], 0);
        ps2_data = 1'b1;
    endtask

    task automatic checkpoint(input string tag);
        wait_cyc(20);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_errs"}, obs_err, exp_err);
        check({tag, "_key_down"}, key_down, m_down);
        check({tag, "_key_code"}, key_code, m_code);
        check({tag, "_key_release"}, key_release, m_rel);
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge inclk) begin
        logic [9:0] e;
        if (frame_err) begin
            obs_err++;
            check("err_with_valid", key_valid, 0);
        end
        if (key_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("event", {key_release, key_code}, e);
                check("latency", cyc - last_stop_cyc, FL + 5);
            end
        end
    end

    // Main sequence
    initial begin
        logic [7:0] b;
        int         sel;
        int         bad;
        model_reset();
        reset = 1'b0;
        wait_cyc(5);
        check("rst_key_code", key_code, 0);
        check("rst_key_release", key_release, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_down", key_down, 0);
        check("rst_frame_err", frame_err, 0);
        reset = 1'b1;
        wait_cyc(5);

        // Reset in the middle of a frame
        send_partial(8'h1C, 4);
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        model_reset();
        wait_cyc(5);
        send_frame(8'h1C, 0, 0);
        checkpoint("rst_mid");

        // Make then break
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        checkpoint("make_break");

        // Extended break, then plain make of the same scan byte
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        checkpoint("ext_break");
        send_frame(8'h75, 0, 0);
        checkpoint("plain_75");

        // Parity error then recovery
        send_frame(8'h1C, 1, 0);
        checkpoint("parity_err");
        send_frame(8'h1B, 0, 0);
        checkpoint("after_parity");

        // Short clock glitch with data low must not start a frame
        ps2_data = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(2);
        ps2_data = 1'b1;
        wait_cyc(30);
        checkpoint("glitch");
        send_frame(8'h1C, 0, 0);
        checkpoint("after_glitch");

        // Timeout on a partial frame also drops a pending E0 prefix
        send_frame(8'hE0, 0, 0);
        send_partial(8'h5A, 3);
        wait_cyc(TO + 50);
        exp_err++;
        m_ext = 0; m_brk = 0;
        checkpoint("timeout");
        send_frame(8'h75, 0, 0);
        checkpoint("after_timeout");

        // Auto-repeat sequence
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        checkpoint("typematic");
        check("typematic_up", key_down, 0);

        // Randomized keystroke stream with occasional corrupt frames
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 8'hE0;
                1: b = 8'hF0;
                2: b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                3: b = 8'h1C;
                default: b = 8'($urandom_range(1, 254));
            endcase
            bad = $urandom_range(0, 9);
            send_frame(b, bad == 0, bad == 1);
        end
        checkpoint("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyscan.md
Name: ps2_keyscan

Overview:
- PS/2 keyboard front end that sits directly upstream of the piano stage.
- Oversamples the raw ps2_clk/ps2_data pins on the 50 MHz system clock and assembles 11-bit frames.
- Decodes the E0 (extended) and F0 (break) prefixes.
- Delivers one qualified key event per keystroke (code, make/break, valid strobe) for the piano's note lookup and record/replay logic.

Parameters:
- FILTER_LEN, 8, number of consecutive equal synchronized ps2_clk samples required to change the filtered clock level (range 2..16).
- TIMEOUT_CYC, 100000, inclk cycles without a filtered falling edge before a partial frame is abandoned (2 ms at 50 MHz).

Ports:
- inclk  in  1  system clock, 50 MHz, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_data  in  1  raw PS/2 data pin, asynchronous
- key_code  out  9  {ext, scan byte} of last delivered event
- key_release  out  1  1 = last event was break, 0 = make
- key_valid  out  1  one-cycle strobe, key_code/key_release valid this cycle
- key_down  out  1  a make without matching break is outstanding
- frame_err  out  1  one-cycle strobe on parity, stop-bit or timeout error

Behaviour:
- Reset (reset=0 at a rising edge) clears all state. All outputs are 0, the FSM is in IDLE, ext/brk flags are 0, and the filtered clock is 1.
- A reset asserted mid-frame discards the partial frame with no strobe.
- Sync: ps2_clk and ps2_data each pass through a 2-FF synchronizer.
- Filter: shift register of the last FILTER_LEN synced clk samples.
  - All ones -> clk_f=1; all zeros -> clk_f=0; otherwise clk_f holds.
  - A strobe "fall" is asserted for one cycle when clk_f goes 1->0.
  - Data is sampled (synced) in the fall cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: fall with data=0 -> DATA, bit count=0. Fall with data=1 is ignored; stay in IDLE.
  - DATA: each fall shifts data into the byte, LSB first. After the 8th bit -> PARITY.
  - PARITY: fall latches the parity bit -> STOP.
  - STOP: fall checks the frame, then -> IDLE.
    - Stop=1 and odd parity over 8 data bits plus the parity bit correct -> internal byte_rdy pulses the next cycle.
    - Otherwise frame_err pulses the next cycle.
- Timeout: the counter clears on every fall and while in IDLE.
  - In any other state, reaching TIMEOUT_CYC-1 forces IDLE and pulses frame_err.
  - A fall in the same cycle as the timeout takes priority: the counter clears and no error is raised.
- Decoder, acting on byte_rdy:
  - Byte E0 -> ext=1, no event.
  - Byte F0 -> brk=1, no event.
  - Bytes 00 and FF (keyboard overrun) -> discarded, ext/brk cleared.
  - Any other byte -> next cycle: key_valid=1, key_code={ext,byte}, key_release=brk; ext and brk cleared.
- Latency: key_valid rises exactly 2 inclk cycles after the fall strobe of the final frame's stop bit.
- key_code and key_release hold their value until the next event.
- frame_err clears ext and brk, so a corrupted multi-byte sequence never yields a stale prefix.
- key_down tracking:
  - A make event sets key_down and stores the code in held_code.
  - A break event whose code equals held_code clears key_down.
  - A break of a different code leaves key_down unchanged.
- Simultaneous events: byte_rdy and frame_err are mutually exclusive by construction. key_valid never coincides with frame_err.

Optional Feature:
- Macro PS2_TYPEMATIC_FILTER_EN.
- Defined: a make event whose {ext,byte} equals held_code while key_down=1 is suppressed (no key_valid, outputs unchanged), so keyboard auto-repeat does not retrigger notes. Break events are never suppressed.
- Undefined: every make, including auto-repeat, produces key_valid.

Test Plan:
- Reset mid-frame: send start plus 4 bits of 0x1C, assert reset=0 for 1 cycle, then send a full 0x1C frame -> exactly one key_valid, key_code=0x01C, key_release=0, frame_err never asserted.
- Make/break: frames 0x1C, F0, 0x1C -> two key_valid pulses: (0x01C, release=0) then (0x01C, release=1). key_down goes 1 then 0. Each key_valid is 2 cycles after the stop fall.
- Extended key: frames E0, F0, 0x75 -> single key_valid, key_code=0x175, key_release=1. The following plain 0x75 frame gives key_code=0x075.
- Parity error: 0x1C frame with parity bit flipped -> frame_err one cycle, no key_valid. A subsequent good 0x1B frame -> key_code=0x01B.
- Glitch and timeout:
  - A 3-cycle low pulse on ps2_clk with FILTER_LEN=8 -> no fall, no state change.
  - Start plus 3 bits, then idle for TIMEOUT_CYC cycles -> frame_err pulse, FSM IDLE, next good frame decoded.
- Typematic: frames 0x1C, 0x1C, 0x1C, F0, 0x1C -> with PS2_TYPEMATIC_FILTER_EN, 2 key_valid pulses; without it, 4 key_valid pulses. key_down=0 at the end in both builds.
